// File: rtl/uart_frame_parser.sv
// Assembles HDR0 HDR1 LEN payload CHK frames from UART byte strobes and releases
// checksum-valid payloads as a valid/ready byte stream. Optional macro: UART_PARSER_TIMEOUT_EN.
module uart_frame_parser #(
  parameter int unsigned MAX_LEN      = 16,
  parameter logic [7:0]  HDR0         = 8'h55,
  parameter logic [7:0]  HDR1         = 8'hAA,
  parameter int unsigned TIMEOUT_CLKS = 50000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_done,
  input  logic [7:0] uart_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic [7:0] frame_len,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int unsigned IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {StHdr0, StHdr1, StLen, StPay, StChk, StOut} state_t;

  state_t     state_q;
  logic       done_q;
  logic [7:0] len_q;
  logic [7:0] sum_q;
  logic [7:0] wr_idx_q;
  logic [7:0] rd_idx_q;
  logic [7:0] pay_mem [MAX_LEN];

  logic       byte_stb;
  logic [7:0] rd_nxt;

  assign byte_stb = uart_done & ~done_q;
  assign rd_nxt   = rd_idx_q + 8'd1;
  assign busy     = (state_q != StHdr0);

`ifdef UART_PARSER_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  logic [CNT_W-1:0] idle_q;
  logic             in_timed_state;
  assign in_timed_state = (state_q == StHdr1) || (state_q == StLen) ||
                          (state_q == StPay)  || (state_q == StChk);
`endif

  // Payload buffer has no reset; contents are only read after being written.
  always_ff @(posedge sys_clk) begin
    if (state_q == StPay && byte_stb) begin
      pay_mem[wr_idx_q[IDX_W-1:0]] <= uart_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= StHdr0;
      done_q    <= 1'b0;
      len_q     <= 8'd0;
      sum_q     <= 8'd0;
      wr_idx_q  <= 8'd0;
      rd_idx_q  <= 8'd0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      out_last  <= 1'b0;
      frame_len <= 8'd0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
`ifdef UART_PARSER_TIMEOUT_EN
      idle_q    <= '0;
`endif
    end else begin
      done_q    <= uart_done;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state_q)
        StHdr0: begin
          if (byte_stb && uart_data == HDR0) state_q <= StHdr1;
        end
        StHdr1: begin
          if (byte_stb) begin
            if (uart_data == HDR1)      state_q <= StLen;
            else if (uart_data != HDR0) state_q <= StHdr0;
          end
        end
        StLen: begin
          if (byte_stb) begin
            if (uart_data == 8'd0 || uart_data > MAX_LEN_B) begin
              frame_err <= 1'b1;
              err_code  <= 2'd0;
              state_q   <= StHdr0;
            end else begin
              len_q    <= uart_data;
              sum_q    <= uart_data;
              wr_idx_q <= 8'd0;
              state_q  <= StPay;
            end
          end
        end
        StPay: begin
          if (byte_stb) begin
            sum_q    <= sum_q + uart_data;
            wr_idx_q <= wr_idx_q + 8'd1;
            if (wr_idx_q == len_q - 8'd1) state_q <= StChk;
          end
        end
        StChk: begin
          if (byte_stb) begin
            if (uart_data == sum_q) begin
              frame_ok  <= 1'b1;
              rd_idx_q  <= 8'd0;
              out_valid <= 1'b1;
              out_data  <= pay_mem[0];
              out_last  <= (len_q == 8'd1);
              frame_len <= len_q;
              state_q   <= StOut;
            end else begin
              frame_err <= 1'b1;
              err_code  <= 2'd1;
              state_q   <= StHdr0;
            end
          end
        end
        StOut: begin
          // Bytes arriving while the buffer drains cannot be stored.
          if (byte_stb) begin
            frame_err <= 1'b1;
            err_code  <= 2'd3;
          end
          if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state_q   <= StHdr0;
            end else begin
              rd_idx_q <= rd_nxt;
              out_data <= pay_mem[rd_nxt[IDX_W-1:0]];
              out_last <= (rd_nxt == len_q - 8'd1);
            end
          end
        end
        default: state_q <= StHdr0;
      endcase
`ifdef UART_PARSER_TIMEOUT_EN
      // Every entry into a timed state is caused by a strobe, so clearing on
      // strobe also clears on state entry.
      if (byte_stb || !in_timed_state) begin
        idle_q <= '0;
      end else if (idle_q == CNT_W'(TIMEOUT_CLKS - 1)) begin
        idle_q    <= '0;
        frame_err <= 1'b1;
        err_code  <= 2'd2;
        state_q   <= StHdr0;
      end else begin
        idle_q <= idle_q + CNT_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Randomized and directed bench for uart_frame_parser, checked every cycle against a
// byte-queue model of the framing rules.
module tb_uart_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int TO      = 100;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       sys_rst, uart_done, out_ready, out_valid, out_last, frame_ok, frame_err, busy;
  logic [7:0] uart_data, out_data, frame_len;
  logic [1:0] err_code;

  uart_frame_parser #(.MAX_LEN(MAX_LEN), .HDR0(8'h55), .HDR1(8'hAA), .TIMEOUT_CLKS(TO)) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .uart_done(uart_done), .uart_data(uart_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frame_len(frame_len), .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: rx holds the candidate frame seen so far, outq the payload still to deliver.
  bq_t        rx, outq;
  logic [7:0] m_flen = 8'd0;
  bit         m_ok = 1'b0, m_err = 1'b0, m_done = 1'b0;
  logic [1:0] m_code = 2'd0;
  int         m_since = 0;

  task automatic model_byte(input logic [7:0] b);
    int n;
    logic [7:0] s;
    n = rx.size();
    if (n == 0) begin
      if (b == 8'h55) rx.push_back(b);
    end else if (n == 1) begin
      if (b == 8'hAA) rx.push_back(b);
      else if (b != 8'h55) rx.delete();
    end else if (n == 2) begin
      if (b == 8'd0 || int'(b) > MAX_LEN) begin
        m_err = 1'b1; m_code = 2'd0; rx.delete();
      end else rx.push_back(b);
    end else if (n < 3 + int'(rx[2])) begin
      rx.push_back(b);
    end else begin
      s = rx[2];
      for (int i = 3; i < n; i++) s = s + rx[i];
      if (b == s) begin
        m_ok = 1'b1;
        m_flen = rx[2];
        for (int i = 3; i < n; i++) outq.push_back(rx[i]);
      end else begin
        m_err = 1'b1; m_code = 2'd1;
      end
      rx.delete();
    end
  endtask

  initial begin
    bit stb, outputting;
    forever begin
      @(posedge clk);
      m_ok = 1'b0;
      m_err = 1'b0;
      if (sys_rst) begin
        rx.delete(); outq.delete();
        m_done = 1'b0; m_code = 2'd0; m_flen = 8'd0; m_since = 0;
      end else begin
        stb = uart_done && !m_done;
        m_done = uart_done;
        outputting = outq.size() > 0;
        if (outputting && out_ready) void'(outq.pop_front());
        if (stb) begin
          m_since = 0;
          if (outputting) begin
            m_err = 1'b1; m_code = 2'd3;
          end else model_byte(uart_data);
        end
`ifdef UART_PARSER_TIMEOUT_EN
        else if (!outputting && rx.size() > 0) begin
          m_since++;
          if (m_since == TO) begin
            m_err = 1'b1; m_code = 2'd2; rx.delete(); m_since = 0;
          end
        end
`endif
      end
    end
  end

  // Logs of observed events for the directed literal checks.
  int  ok_cnt = 0;
  bq_t err_log, delivered, last_log, fl_log;

  task automatic clear_logs();
    ok_cnt = 0;
    err_log.delete(); delivered.delete(); last_log.delete(); fl_log.delete();
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("out_valid", out_valid, outq.size() > 0);
      if (outq.size() > 0) begin
        check("out_data", out_data, outq[0]);
        check("out_last", out_last, outq.size() == 1);
        check("frame_len", frame_len, m_flen);
      end
      check("frame_ok", frame_ok, m_ok);
      check("frame_err", frame_err, m_err);
      check("err_code", err_code, m_code);
      check("busy", busy, rx.size() > 0 || outq.size() > 0);
      if (frame_ok) ok_cnt++;
      if (frame_err) err_log.push_back({6'd0, err_code});
      if (out_valid && out_ready) begin
        delivered.push_back(out_data);
        last_log.push_back({7'd0, out_last});
        fl_log.push_back(frame_len);
      end
    end
  end

  int rdy_mode = 0;  // 0 always, 1 toggle, 2 random, 3 never
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int w, input int g);
    uart_data = b;
    uart_done = 1'b1;
    tick(w);
    uart_done = 1'b0;
    tick(g);
  endtask

  task automatic send_seq(input bq_t s, input int w, input int g);
    foreach (s[i]) send_byte(s[i], w, g);
  endtask

  task automatic wait_idle(input string name, input int max);
    for (int i = 0; i < max && busy; i++) tick(1);
    check(name, busy, 1'b0);
  endtask

  task automatic check_bytes(input string name, input bq_t got, input bq_t exp);
    check({name, "_n"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) check(name, got[i], exp[i]);
  endtask

  task automatic pulse_reset();
    sys_rst = 1'b1;
    tick(1);
    sys_rst = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int L, kind;
    logic [7:0] s;
    bq_t f;
    sys_rst = 1'b1; uart_done = 1'b0; uart_data = 8'd0;
    tick(3);
    sys_rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_code", err_code, 2'd0);

    // Good frame, wide strobe.
    clear_logs();
    send_seq({8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, 200, 2);
    wait_idle("t1_idle", 100);
    check("t1_ok", ok_cnt, 1);
    check("t1_errs", err_log.size(), 0);
    check_bytes("t1_data", delivered, {8'h11, 8'h22, 8'h33});
    check_bytes("t1_last", last_log, {8'h0, 8'h0, 8'h1});
    check("t1_flen", fl_log.size() > 0 ? fl_log[0] : 8'd0, 3);

    // Backpressure.
    clear_logs();
    rdy_mode = 1;
    send_seq({8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, 3, 1);
    wait_idle("t2_idle", 200);
    check_bytes("t2_data", delivered, {8'h11, 8'h22, 8'h33});

    // Bad checksum then good one-byte frame.
    clear_logs();
    rdy_mode = 0;
    send_seq({8'h55, 8'hAA, 8'h02, 8'h01, 8'h02, 8'h00}, 2, 1);
    check("t3_novalid", delivered.size(), 0);
    send_seq({8'h55, 8'hAA, 8'h01, 8'h05, 8'h06}, 2, 1);
    wait_idle("t3_idle", 100);
    check_bytes("t3_errs", err_log, {8'd1});
    check_bytes("t3_data", delivered, {8'h05});
    check_bytes("t3_last", last_log, {8'h1});

    // Length errors and resync.
    clear_logs();
    send_seq({8'h55, 8'hAA, 8'h00, 8'h55, 8'hAA, 8'h11}, 1, 2);
    send_seq({8'h55, 8'h55, 8'hAA, 8'h01, 8'h7F, 8'h80}, 2, 1);
    wait_idle("t4_idle", 100);
    check_bytes("t4_errs", err_log, {8'd0, 8'd0});
    check_bytes("t4_data", delivered, {8'h7F});
    check("t4_ok", ok_cnt, 1);

    // Drop during output.
    clear_logs();
    rdy_mode = 3;
    send_seq({8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69, 8'h12}, 2, 2);
    check_bytes("t5_errs", err_log, {8'd3});
    check("t5_held", delivered.size(), 0);
    rdy_mode = 0;
    wait_idle("t5_idle", 100);
    check_bytes("t5_data", delivered, {8'h11, 8'h22, 8'h33});

    // Partial frame then silence.
    clear_logs();
    send_seq({8'h55, 8'hAA, 8'h04, 8'h01}, 2, 1);
    tick(150);
`ifdef UART_PARSER_TIMEOUT_EN
    check_bytes("t6_errs", err_log, {8'd2});
    check("t6_busy", busy, 1'b0);
`else
    check("t6_errs", err_log.size(), 0);
    check("t6_busy", busy, 1'b1);
`endif
    pulse_reset();

    // Randomized traffic, including drops, bad lengths/checksums and resets.
    rdy_mode = 2;
    for (int it = 0; it < 80; it++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        send_byte(8'($urandom), $urandom_range(1, 3), $urandom_range(1, 3));
      end else if (kind == 1) begin
        pulse_reset();
      end else begin
        if (kind > 2) begin
          for (int i = 0; i < 1000 && out_valid; i++) tick(1);
        end
        L = ($urandom_range(0, 7) == 0) ? $urandom_range(0, MAX_LEN + 2) :
                                           $urandom_range(1, MAX_LEN);
        f = {8'h55, 8'hAA, 8'(L)};
        s = 8'(L);
        for (int i = 0; i < L; i++) begin
          f.push_back(8'($urandom));
          s = s + f[f.size() - 1];
        end
        if ($urandom_range(0, 4) == 0) s = s ^ 8'(1 << $urandom_range(0, 7));
        f.push_back(s);
        foreach (f[i]) send_byte(f[i], $urandom_range(1, 3), $urandom_range(1, 3));
      end
    end
    rdy_mode = 0;
    tick(40);
    pulse_reset();
    check("end_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
